// File: rtl/step_issue_ctrl.sv
// step_issue_ctrl: config/run/drain sequencer driving skewed per-lane valid/last/user.
// Optional stall counter port perf_stall_cnt when STEP_ISSUE_PERF_EN is defined.
module step_issue_ctrl #(
  parameter int STEPS             = 4,
  parameter int ACCUMULATOR_DELAY = 4,
  parameter int TUSER_WIDTH       = 8,
  parameter int BEATS_W           = 16
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic                           aclken,
  input  logic                           cfg_valid,
  output logic                           cfg_ready,
  input  logic                           cfg_is_1x1,
  input  logic [BEATS_W-1:0]             cfg_beats,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [STEPS-1:0]               lane_valid,
  output logic [STEPS-1:0]               lane_last,
  output logic [STEPS*TUSER_WIDTH-1:0]   lane_user,
  output logic                           is_1x1,
  output logic                           busy,
  output logic                           done
`ifdef STEP_ISSUE_PERF_EN
  ,
  output logic [31:0]                    perf_stall_cnt
`endif
);

  // Drain covers lane skew plus the accumulator fill for the block's mode.
  localparam int F_3X3 = (STEPS-1)*(ACCUMULATOR_DELAY-2) + 1;
  localparam int D_3X3 = (STEPS-1) + F_3X3;
  localparam int D_1X1 = (STEPS-1) + 1;
  localparam int DW    = $clog2(D_3X3 + 1);

  // Counter holds remaining drain cycles minus one, so 0 means last one.
  localparam logic [DW-1:0] DRN_3X3 = DW'(D_3X3 - 1);
  localparam logic [DW-1:0] DRN_1X1 = DW'(D_1X1 - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [BEATS_W-1:0] beats_q, beats_d;
  logic [BEATS_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]      drn_q, drn_d;
  logic               mode_q, mode_d;

  logic [STEPS-1:0]                  vld_q, vld_d;
  logic [STEPS-1:0]                  lst_q, lst_d;
  logic [STEPS-1:0][TUSER_WIDTH-1:0] usr_q, usr_d;

  logic                   cfg_fire;
  logic                   beat_fire;
  logic                   beat_last;
  logic                   beat_first;
  logic [TUSER_WIDTH-1:0] u0;

  assign cfg_ready  = aclken & (state_q == S_IDLE);
  assign in_ready   = aclken & (state_q == S_RUN);
  assign cfg_fire   = cfg_valid & cfg_ready;
  assign beat_fire  = in_valid & in_ready;
  assign beat_last  = (cnt_q == beats_q - 1'b1);
  assign beat_first = (cnt_q == '0);

  assign lane_valid = vld_q;
  assign lane_last  = lst_q;
  assign lane_user  = usr_q;
  assign is_1x1     = mode_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);

  // Lane 0 user word: first-beat flag and mode, qualified by the beat.
  always_comb begin
    u0    = '0;
    u0[0] = beat_fire & beat_first;
    u0[1] = beat_fire & mode_q;
  end

  // Block sequencing: config latch, beat counting, drain countdown.
  always_comb begin
    state_d = state_q;
    beats_d = beats_q;
    cnt_d   = cnt_q;
    drn_d   = drn_q;
    mode_d  = mode_q;
    unique case (state_q)
      S_IDLE: begin
        if (cfg_fire) begin
          state_d = S_RUN;
          mode_d  = cfg_is_1x1;
          beats_d = (cfg_beats == '0) ? BEATS_W'(1) : cfg_beats;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (beat_fire) begin
          if (beat_last) begin
            state_d = S_DRAIN;
            drn_d   = mode_q ? DRN_1X1 : DRN_3X3;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (drn_q == '0) begin
          state_d = S_DONE;
        end else begin
          drn_d = drn_q - 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Skew chain: lane 0 takes the new beat, lane i takes lane i-1.
  always_comb begin
    vld_d = {vld_q[STEPS-2:0], beat_fire};
    lst_d = {lst_q[STEPS-2:0], beat_fire & beat_last};
    usr_d = {usr_q[STEPS-2:0], u0};
  end

  // Control state registers, frozen while the clock enable is low.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= S_IDLE;
      beats_q <= BEATS_W'(1);
      cnt_q   <= '0;
      drn_q   <= '0;
      mode_q  <= 1'b0;
    end else if (aclken) begin
      state_q <= state_d;
      beats_q <= beats_d;
      cnt_q   <= cnt_d;
      drn_q   <= drn_d;
      mode_q  <= mode_d;
    end
  end

  // Lane shift chain registers, frozen while the clock enable is low.
  always_ff @(posedge aclk) begin
    if (areset) begin
      vld_q <= '0;
      lst_q <= '0;
      usr_q <= '0;
    end else if (aclken) begin
      vld_q <= vld_d;
      lst_q <= lst_d;
      usr_q <= usr_d;
    end
  end

`ifdef STEP_ISSUE_PERF_EN
  logic [31:0] stall_q;

  assign perf_stall_cnt = stall_q;

  // Saturating count of enabled RUN cycles with no upstream beat.
  always_ff @(posedge aclk) begin
    if (areset) begin
      stall_q <= '0;
    end else if (aclken) begin
      if (cfg_fire) begin
        stall_q <= '0;
      end else if (state_q == S_RUN && !in_valid && stall_q != '1) begin
        stall_q <= stall_q + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_step_issue_ctrl.sv
// tb_step_issue_ctrl: directed block scenarios plus random traffic
// checked every cycle against a history-based reference model.
module tb_step_issue_ctrl;

  localparam int STEPS = 4;
  localparam int ACD   = 4;
  localparam int TW    = 8;
  localparam int BW    = 16;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic                aresetr = 1'b1;
  logic                aclken = 1'b1;
  logic                cfg_valid = 1'b0;
  logic                cfg_ready;
  logic                cfg_is_1x1 = 1'b0;
  logic [BW-1:0]       cfg_beats = '0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [STEPS-1:0]    lane_valid;
  logic [STEPS-1:0]    lane_last;
  logic [STEPS*TW-1:0] lane_user;
  logic                is_1x1;
  logic                busy;
  logic                done;
`ifdef STEP_ISSUE_PERF_EN
  logic [31:0]         perf_stall_cnt;
`endif

  step_issue_ctrl #(
    .STEPS(STEPS), .ACCUMULATOR_DELAY(ACD),
    .TUSER_WIDTH(TW), .BEATS_W(BW)
  ) dut (
    .aclk(aclk), .areset(aresetr), .aclken(aclken),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_is_1x1(cfg_is_1x1), .cfg_beats(cfg_beats),
    .in_valid(in_valid), .in_ready(in_ready),
    .lane_valid(lane_valid), .lane_last(lane_last),
    .lane_user(lane_user), .is_1x1(is_1x1),
    .busy(busy), .done(done)
`ifdef STEP_ISSUE_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  int n_tot = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: block phase, beats taken, drain cycles left,
  // and a per-enabled-cycle history of what lane 0 emitted.
  int          ph = 0;   // 0 idle, 1 run, 2 drain, 3 done
  int          m_beats = 1;
  int          m_taken = 0;
  int          m_left = 0;
  bit          m_mode = 0;
  longint      m_perf = 0;
  bit          hv[$];
  bit          hl[$];
  bit [TW-1:0] hu[$];

  int  ecount = 0;
  int  done_at = -1;
  int  n_done = 0;
  int  n_l3 = 0;
  int  n_l2 = 0;
  bit  chk_en = 0;

  function automatic int dlen(input bit m);
    return (STEPS-1) + (m ? 1 : (STEPS-1)*(ACD-2) + 1);
  endfunction

  task automatic hist_clear();
    hv.delete(); hl.delete(); hu.delete();
    for (int i = 0; i < STEPS; i++) begin
      hv.push_back(1'b0); hl.push_back(1'b0); hu.push_back('0);
    end
  endtask

  task automatic mdl_edge();
    bit          nv;
    bit          nl;
    bit [TW-1:0] nu;
    nv = 0; nl = 0; nu = '0;
    if (aresetr) begin
      ph = 0; m_mode = 0; m_taken = 0; m_left = 0; m_perf = 0;
      hist_clear();
    end else if (aclken) begin
      case (ph)
        0: if (cfg_valid) begin
          ph = 1;
          m_mode = cfg_is_1x1;
          m_beats = (cfg_beats == 0) ? 1 : int'(cfg_beats);
          m_taken = 0;
          m_perf = 0;
        end
        1: if (in_valid) begin
          nv = 1;
          nu[0] = (m_taken == 0);
          nu[1] = m_mode;
          m_taken++;
          if (m_taken == m_beats) begin
            nl = 1;
            ph = 2;
            m_left = dlen(m_mode);
          end
        end else if (m_perf < 64'hFFFF_FFFF) begin
          m_perf++;
        end
        2: begin
          m_left--;
          if (m_left == 0) ph = 3;
        end
        default: ph = 0;
      endcase
      hv.push_front(nv); void'(hv.pop_back());
      hl.push_front(nl); void'(hl.pop_back());
      hu.push_front(nu); void'(hu.pop_back());
    end
  endtask

  task automatic chk_all();
    logic [STEPS-1:0]    ev;
    logic [STEPS-1:0]    el;
    logic [STEPS*TW-1:0] eu;
    for (int i = 0; i < STEPS; i++) begin
      ev[i] = hv[i];
      el[i] = hl[i];
      eu[i*TW +: TW] = hu[i];
    end
    chk("cfg_ready", cfg_ready, aclken && ph == 0);
    chk("in_ready", in_ready, aclken && ph == 1);
    chk("busy", busy, ph != 0);
    chk("done", done, ph == 3);
    chk("is_1x1", is_1x1, m_mode);
    chk("lane_valid", lane_valid, ev);
    chk("lane_last", lane_last, el);
    chk("lane_user", lane_user, eu);
`ifdef STEP_ISSUE_PERF_EN
    chk("perf", perf_stall_cnt, m_perf);
`endif
  endtask

  // One cycle: drive at negedge, check, clock, advance the model.
  task automatic cyc(input bit rst, input bit en, input bit cv,
                     input bit c1, input int cb, input bit iv);
    aresetr = rst; aclken = en; cfg_valid = cv;
    cfg_is_1x1 = c1; cfg_beats = BW'(cb); in_valid = iv;
    #1;
    if (chk_en) chk_all();
    if (done === 1'b1) begin
      n_done++;
      if (done_at < 0) done_at = ecount;
    end
    if (lane_valid[3] === 1'b1) n_l3++;
    if (lane_valid[2] === 1'b1) n_l2++;
    @(posedge aclk);
    mdl_edge();
    ecount++;
    @(negedge aclk);
  endtask

  // Config, then in_valid held high until done; optional 5-cycle
  // enable drop in drain. Latency counts cycles after the last accept.
  task automatic blk(input bit m, input int cb, input bit frz,
                     output int lat);
    int nb;
    int a;
    bit en;
    nb = (cb == 0) ? 1 : cb;
    lat = -1;
    done_at = -1;
    n_l3 = 0;
    cyc(0, 1, 1, m, cb, 0);
    a = ecount;
    for (int k = 0; k < 80 && done_at < 0; k++) begin
      en = !(frz && k >= nb + 2 && k < nb + 7);
      cyc(0, en, 0, 0, 0, 1);
    end
    if (done_at >= 0) lat = done_at - (a + nb) + 1;
  endtask

  int lat;

  initial begin
    hist_clear();
    @(negedge aclk);
    cyc(1, 1, 0, 0, 0, 0);
    chk_en = 1;
    cyc(1, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    chk("rst_cfg_ready", cfg_ready, 1'b1);
    chk("rst_lane_valid", lane_valid, '0);

    blk(0, 3, 0, lat);
    chk("lat_3x3", lat, 11);
    chk("lane3_beats", n_l3, 3);

    blk(1, 3, 0, lat);
    chk("lat_1x1", lat, 5);

    blk(0, 3, 1, lat);
    chk("lat_frozen", lat, 16);

    blk(0, 0, 0, lat);
    chk("lat_beats0", lat, 11);

    // Bubble pattern 1,0,1,1,1 on a 4-beat block.
    cyc(0, 1, 1, 0, 4, 0);
    n_l2 = 0;
    cyc(0, 1, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) cyc(0, 1, 0, 0, 0, 1);
`ifdef STEP_ISSUE_PERF_EN
    chk("perf_one", perf_stall_cnt, 32'd1);
`endif
    for (int k = 0; k < 16; k++) cyc(0, 1, 0, 0, 0, 0);
    chk("lane2_beats", n_l2, 4);

    // Reset in drain: no done afterwards, next block completes.
    cyc(0, 1, 1, 0, 2, 0);
    for (int k = 0; k < 5; k++) cyc(0, 1, 0, 0, 0, 1);
    cyc(1, 1, 0, 0, 0, 0);
    n_done = 0;
    for (int k = 0; k < 20; k++) cyc(0, 1, 0, 0, 0, 0);
    chk("rst_no_done", n_done, 0);
    blk(0, 1, 0, lat);
    chk("lat_after_rst", lat, 11);

    for (int k = 0; k < 3000; k++) begin
      cyc($urandom_range(99) == 0, $urandom_range(9) != 0,
          $urandom_range(1), $urandom_range(1),
          $urandom_range(6), $urandom_range(3) != 0);
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
